car_detect_ctrl: RTL and testbench
==================================

CAR_DETECT_CTRL -- requirements
Module: car_detect_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, the consecutive cycles a synchronized sensor level must hold before it is accepted.
REQ-002 SHALL have parameter STUCK_CYCLES, default 255, the consecutive cycles of accepted-high level that declare a stuck sensor.
REQ-003 SHALL have port CLOCK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port CLEAR, input, 1 bit, the reset: synchronous, active-low.
REQ-005 SHALL have port LOOP_RAW, input, 1 bit, the raw country-road loop sensor, asynchronous to CLOCK and possibly bouncing.
REQ-006 SHALL have port CNTRY_SIG, input, 2 bits, the country-road lamp state from sig_control (RED=0, YELLOW=1, GREEN=2).
REQ-007 SHALL have port CAR_ON_CNTRY_RD, output, 1 bit, the registered request that feeds sig_control.
REQ-008 SHALL have port CAR_COUNT, output, 8 bits, the registered count of cars waiting or passing.
REQ-009 SHALL have port DET_FAULT, output, 1 bit, the registered stuck-sensor flag.

Function
REQ-010 SHALL pass LOOP_RAW through a 2-flop synchronizer before any other use.
REQ-011 SHALL change the filtered level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the run count at 0.
REQ-012 SHALL run an FSM with states IDLE (filtered low), OCCUPIED (filtered high) and FAULT.
REQ-013 SHALL move IDLE->OCCUPIED on a filtered rise and OCCUPIED->IDLE on a filtered fall.
REQ-014 SHALL move OCCUPIED->FAULT when the filtered level has been high for STUCK_CYCLES consecutive cycles, and FAULT->IDLE on a filtered fall.
REQ-015 SHALL, on an IDLE->OCCUPIED transition (arrival), increment CAR_COUNT, saturating at 255.
REQ-016 SHALL, on an OCCUPIED->IDLE transition (departure) while CNTRY_SIG==GREEN, decrement CAR_COUNT, flooring at 0.
REQ-017 SHALL leave CAR_COUNT unchanged on a departure while CNTRY_SIG is RED or YELLOW (the car is still waiting).
REQ-018 SHALL clear CAR_COUNT to 0 on entry to FAULT and hold it at 0 while in FAULT.
REQ-019 SHALL register CAR_ON_CNTRY_RD one cycle after CAR_COUNT as (CAR_COUNT!=0) OR DET_FAULT; in fault the request fails safe by being forced high.
REQ-020 SHALL set DET_FAULT high exactly while in FAULT, registered in the same cycle as the state.
REQ-021 SHALL give a latency from the first CLOCK edge sampling LOOP_RAW high to CAR_COUNT update of 2+DEBOUNCE_CYCLES+1 edges, and to CAR_ON_CNTRY_RD of one further edge (8 edges at the default).
REQ-022 SHALL treat a CNTRY_SIG value of 3 as RED.
REQ-023 SHALL ignore LOOP_RAW pulses shorter than DEBOUNCE_CYCLES synchronized cycles entirely, with no count change.

Reset
REQ-024 SHALL, on any rising edge with CLEAR==0, set the state to IDLE, clear the synchronizer, filtered level and all run counters, and set CAR_COUNT=0, CAR_ON_CNTRY_RD=0, DET_FAULT=0.
REQ-025 SHALL, when CLEAR is asserted mid-debounce or in FAULT, discard the partial state and restart cleanly from IDLE on the first edge with CLEAR==1.

Structure
REQ-026 SHALL place the lamp encodings RED/YELLOW/GREEN and the FSM state encodings in a shared package traffic_pkg, which sig_control also uses.
REQ-027 SHALL implement the synchronizer plus debouncer as one sub-module, loop_debounce, parameterized by DEBOUNCE_CYCLES; the FSM and counter live in car_detect_ctrl.

Verification
REQ-028 SHALL cover a clean arrival: LOOP_RAW 0->1 held 20 cycles, CNTRY_SIG=RED -> CAR_COUNT=1 after 7 edges, CAR_ON_CNTRY_RD=1 after 8; LOOP_RAW drop leaves CAR_COUNT=1.
REQ-029 SHALL cover bounce rejection: 3-cycle LOOP_RAW pulses separated by 2-cycle gaps for 40 cycles -> CAR_COUNT stays 0 and CAR_ON_CNTRY_RD stays 0.
REQ-030 SHALL cover counted service: 3 arrivals under RED (CAR_COUNT=3), then CNTRY_SIG=GREEN with 3 departures -> CAR_COUNT 3->2->1->0, then CAR_ON_CNTRY_RD=0 one cycle after CAR_COUNT reaches 0; an extra departure keeps CAR_COUNT=0.
REQ-031 SHALL cover saturation: 260 arrivals under RED -> CAR_COUNT saturates at 255.
REQ-032 SHALL cover a stuck sensor: LOOP_RAW held high 300 cycles -> DET_FAULT=1, CAR_COUNT=0, CAR_ON_CNTRY_RD=1; LOOP_RAW low for 4 cycles -> IDLE, DET_FAULT=0.
REQ-033 SHALL cover reset mid-operation: CLEAR=0 for 1 cycle while CAR_COUNT=2 and a debounce is in progress -> all outputs 0 next edge, and no phantom arrival afterward.

Source files
------------

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared encodings for the traffic-light controller family.
//   lamp_t      : country-road lamp state driven by sig_control
//                 (RED=0, YELLOW=1, GREEN=2; the unused code 3 reads as RED)
//   det_state_t : car detector FSM states
//   COUNT_MAX   : saturation value of the waiting-car counter
//   is_green()  : true only for GREEN, so code 3 is never mistaken for go
// ---------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        YELLOW = 2'd1,
        GREEN  = 2'd2
    } lamp_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OCCUPIED = 2'd1,
        FAULT    = 2'd2
    } det_state_t;

    localparam logic [7:0] COUNT_MAX = 8'd255;

    function automatic logic is_green(input logic [1:0] sig);
        return (sig == GREEN);
    endfunction

endpackage

// File: rtl/loop_debounce.sv
// ---------------------------------------------------------------------------
// loop_debounce
// Brings the asynchronous loop sensor into the clock domain through a
// 2-flop synchronizer, then only accepts a new level once the synchronized
// value has disagreed with the accepted level for DEBOUNCE_CYCLES cycles
// in a row. Any agreeing cycle restarts the run.
// Ports:
//   i_clk     : clock, rising edge
//   i_clear_n : synchronous active-low reset
//   i_raw     : raw loop sensor, asynchronous, may bounce
//   o_level   : registered, debounced level
// ---------------------------------------------------------------------------
module loop_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_clear_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] RUN_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync_p0;
    logic          r_sync_p1;
    logic          r_level;
    logic [CW-1:0] r_run;

    always_ff @(posedge i_clk) begin
        if (!i_clear_n) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_level   <= 1'b0;
            r_run     <= '0;
        end else begin
            // synchronizer stage
            r_sync_p0 <= i_raw;
            r_sync_p1 <= r_sync_p0;
            // debounce stage: the run counts disagreeing cycles already seen,
            // so the flip happens on the DEBOUNCE_CYCLES-th one
            if (r_sync_p1 != r_level) begin
                if (r_run == RUN_LAST) begin
                    r_level <= r_sync_p1;
                    r_run   <= '0;
                end else begin
                    r_run <= r_run + CW'(1);
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/car_detect_ctrl.sv
// ---------------------------------------------------------------------------
// car_detect_ctrl
// Country-road car detector. The debounced loop level drives a small FSM
// (IDLE / OCCUPIED / FAULT) that counts arrivals, retires cars that leave
// under GREEN, and flags a sensor that stays high too long. The request to
// sig_control is raised while any car is counted, and forced high in fault
// so a broken sensor can never starve the country road.
// Ports:
//   CLOCK           : clock, rising edge
//   CLEAR           : synchronous active-low reset
//   LOOP_RAW        : raw loop sensor (asynchronous)
//   CNTRY_SIG       : country-road lamp state (RED/YELLOW/GREEN, 3 = RED)
//   CAR_ON_CNTRY_RD : registered request to sig_control
//   CAR_COUNT       : registered count of waiting/passing cars (0..255)
//   DET_FAULT       : registered stuck-sensor flag
// ---------------------------------------------------------------------------
module car_detect_ctrl
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 255
) (
    input  logic       CLOCK,
    input  logic       CLEAR,
    input  logic       LOOP_RAW,
    input  logic [1:0] CNTRY_SIG,
    output logic       CAR_ON_CNTRY_RD,
    output logic [7:0] CAR_COUNT,
    output logic       DET_FAULT
);

    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);

    logic          w_level;
    det_state_t    r_state;
    logic [7:0]    r_count;
    logic          r_fault;
    logic          r_req;
    logic [SW-1:0] r_stuck;

    loop_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk     (CLOCK),
        .i_clear_n (CLEAR),
        .i_raw     (LOOP_RAW),
        .o_level   (w_level)
    );

    always_ff @(posedge CLOCK) begin
        if (!CLEAR) begin
            r_state <= IDLE;
            r_count <= 8'd0;
            r_fault <= 1'b0;
            r_req   <= 1'b0;
            r_stuck <= '0;
        end else begin
            // request stage trails the count by one edge
            r_req <= (r_count != 8'd0) || r_fault;

            // detector stage
            case (r_state)
                IDLE: begin
                    if (w_level) begin
                        r_state <= OCCUPIED;
                        // the arrival edge is the first high cycle of the run
                        r_stuck <= SW'(1);
                        if (r_count != COUNT_MAX) begin
                            r_count <= r_count + 8'd1;
                        end
                    end
                end
                OCCUPIED: begin
                    if (!w_level) begin
                        r_state <= IDLE;
                        r_stuck <= '0;
                        // a car leaving under RED/YELLOW is still queued
                        if (is_green(CNTRY_SIG) && (r_count != 8'd0)) begin
                            r_count <= r_count - 8'd1;
                        end
                    end else if (r_stuck == STUCK_LAST) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                        r_count <= 8'd0;
                        r_stuck <= '0;
                    end else begin
                        r_stuck <= r_stuck + SW'(1);
                    end
                end
                FAULT: begin
                    r_count <= 8'd0;
                    if (!w_level) begin
                        r_state <= IDLE;
                        r_fault <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_fault <= 1'b0;
                    r_count <= 8'd0;
                    r_stuck <= '0;
                end
            endcase
        end
    end

    assign CAR_ON_CNTRY_RD = r_req;
    assign CAR_COUNT       = r_count;
    assign DET_FAULT       = r_fault;

endmodule

// File: tb/tb_car_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_car_detect_ctrl
// Directed scenarios followed by a randomized stretch. A behavioural model
// (delay line, history of synchronized samples, arrival/departure rules)
// predicts every output on every edge; selected points also carry fixed
// expected constants.
// ---------------------------------------------------------------------------
module tb_car_detect_ctrl;

    localparam int DEB   = 4;
    localparam int STUCK = 255;

    logic       CLOCK     = 1'b0;
    logic       CLEAR     = 1'b0;
    logic       LOOP_RAW  = 1'b0;
    logic [1:0] CNTRY_SIG = 2'd0;
    logic       CAR_ON_CNTRY_RD;
    logic [7:0] CAR_COUNT;
    logic       DET_FAULT;

    always #5 CLOCK = ~CLOCK;

    car_detect_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .STUCK_CYCLES   (STUCK)
    ) dut (
        .CLOCK           (CLOCK),
        .CLEAR           (CLEAR),
        .LOOP_RAW        (LOOP_RAW),
        .CNTRY_SIG       (CNTRY_SIG),
        .CAR_ON_CNTRY_RD (CAR_ON_CNTRY_RD),
        .CAR_COUNT       (CAR_COUNT),
        .DET_FAULT       (DET_FAULT)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    bit raw_q[$];
    bit seen_q[$];
    bit m_filt;
    bit m_occ;
    bit m_flt;
    bit m_req;
    int m_cnt;
    int m_run;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_edge(input bit raw, input bit [1:0] sig, input bit clr);
        bit seen;
        bit lvl;
        bit all_diff;
        if (!clr) begin
            raw_q.delete();
            seen_q.delete();
            m_filt = 1'b0;
            m_occ  = 1'b0;
            m_flt  = 1'b0;
            m_req  = 1'b0;
            m_cnt  = 0;
            m_run  = 0;
        end else begin
            // value reaching the debouncer is the raw input from two edges ago
            seen = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 1'b0;
            raw_q.push_back(raw);
            if (raw_q.size() > 3) void'(raw_q.pop_front());

            lvl   = m_filt;
            m_req = (m_cnt != 0) || m_flt;
            m_run = lvl ? m_run + 1 : 0;

            if (m_flt) begin
                m_cnt = 0;
                if (!lvl) m_flt = 1'b0;
            end else if (!m_occ) begin
                if (lvl) begin
                    m_occ = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (!lvl) begin
                m_occ = 1'b0;
                if (sig == 2'd2 && m_cnt > 0) m_cnt--;
            end else if (m_run == STUCK) begin
                m_occ = 1'b0;
                m_flt = 1'b1;
                m_cnt = 0;
            end

            // level flips once the last DEB samples all disagree with it
            seen_q.push_back(seen);
            if (seen_q.size() > DEB) void'(seen_q.pop_front());
            all_diff = (seen_q.size() == DEB);
            foreach (seen_q[i]) if (seen_q[i] == m_filt) all_diff = 1'b0;
            if (all_diff) begin
                m_filt = ~m_filt;
                seen_q.delete();
            end
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        model_edge(LOOP_RAW, CNTRY_SIG, CLEAR);
        #1;
        chk("count", 32'(CAR_COUNT), 32'(m_cnt));
        chk("req",   32'(CAR_ON_CNTRY_RD), 32'(m_req));
        chk("fault", 32'(DET_FAULT), 32'(m_flt));
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        CLEAR    = 1'b0;
        LOOP_RAW = 1'b0;
        tick();
        CLEAR = 1'b1;
    endtask

    task automatic pulse(input int hi, input int lo);
        LOOP_RAW = 1'b1;
        ticks(hi);
        LOOP_RAW = 1'b0;
        ticks(lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exhausted, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        CLEAR = 1'b0;
        ticks(2);
        chk("rst_count", 32'(CAR_COUNT), 32'd0);
        chk("rst_req",   32'(CAR_ON_CNTRY_RD), 32'd0);
        chk("rst_fault", 32'(DET_FAULT), 32'd0);
        CLEAR = 1'b1;

        // clean arrival under RED, latency 7 to count and 8 to request
        CNTRY_SIG = 2'd0;
        LOOP_RAW  = 1'b1;
        ticks(6);
        chk("arr_count6", 32'(CAR_COUNT), 32'd0);
        tick();
        chk("arr_count7", 32'(CAR_COUNT), 32'd1);
        chk("arr_req7",   32'(CAR_ON_CNTRY_RD), 32'd0);
        tick();
        chk("arr_req8",   32'(CAR_ON_CNTRY_RD), 32'd1);
        ticks(12);
        LOOP_RAW = 1'b0;
        ticks(10);
        chk("arr_drop", 32'(CAR_COUNT), 32'd1);

        // bounce rejection: 3-high / 2-low for 40 cycles
        do_reset();
        repeat (8) pulse(3, 2);
        chk("bounce_count", 32'(CAR_COUNT), 32'd0);
        chk("bounce_req",   32'(CAR_ON_CNTRY_RD), 32'd0);

        // service: three under RED (last one still on the loop), leave under GREEN
        do_reset();
        CNTRY_SIG = 2'd0;
        pulse(8, 8);
        pulse(8, 8);
        LOOP_RAW = 1'b1;
        ticks(8);
        chk("svc_three", 32'(CAR_COUNT), 32'd3);
        CNTRY_SIG = 2'd2;
        LOOP_RAW  = 1'b0;
        ticks(7);
        chk("svc_dep", 32'(CAR_COUNT), 32'd2);
        pulse(8, 8);
        chk("svc_pass_green", 32'(CAR_COUNT), 32'd2);

        // departures under YELLOW and code 3 keep the car queued
        CNTRY_SIG = 2'd0;
        LOOP_RAW  = 1'b1;
        ticks(8);
        CNTRY_SIG = 2'd1;
        LOOP_RAW  = 1'b0;
        ticks(8);
        chk("yellow_hold", 32'(CAR_COUNT), 32'd3);
        CNTRY_SIG = 2'd3;
        pulse(8, 8);
        chk("code3_hold", 32'(CAR_COUNT), 32'd4);

        // last car served: request drops one edge after count reaches 0
        do_reset();
        CNTRY_SIG = 2'd0;
        LOOP_RAW  = 1'b1;
        ticks(8);
        CNTRY_SIG = 2'd2;
        LOOP_RAW  = 1'b0;
        ticks(7);
        chk("svc_zero", 32'(CAR_COUNT), 32'd0);
        chk("svc_req_lag", 32'(CAR_ON_CNTRY_RD), 32'd1);
        tick();
        chk("svc_req_off", 32'(CAR_ON_CNTRY_RD), 32'd0);
        pulse(8, 8);
        chk("svc_floor", 32'(CAR_COUNT), 32'd0);

        // saturation
        do_reset();
        CNTRY_SIG = 2'd0;
        repeat (260) pulse(6, 6);
        chk("sat_count", 32'(CAR_COUNT), 32'd255);

        // stuck sensor
        do_reset();
        pulse(6, 6);
        LOOP_RAW = 1'b1;
        ticks(300);
        chk("stuck_fault", 32'(DET_FAULT), 32'd1);
        chk("stuck_count", 32'(CAR_COUNT), 32'd0);
        chk("stuck_req",   32'(CAR_ON_CNTRY_RD), 32'd1);
        LOOP_RAW = 1'b0;
        ticks(8);
        chk("stuck_clear", 32'(DET_FAULT), 32'd0);

        // reset with count 2 and a debounce in progress
        do_reset();
        CNTRY_SIG = 2'd0;
        pulse(6, 6);
        pulse(6, 6);
        chk("mid_two", 32'(CAR_COUNT), 32'd2);
        LOOP_RAW = 1'b1;
        ticks(3);
        CLEAR = 1'b0;
        tick();
        chk("mid_count", 32'(CAR_COUNT), 32'd0);
        chk("mid_req",   32'(CAR_ON_CNTRY_RD), 32'd0);
        chk("mid_fault", 32'(DET_FAULT), 32'd0);
        CLEAR    = 1'b1;
        LOOP_RAW = 1'b0;
        ticks(20);
        chk("mid_phantom", 32'(CAR_COUNT), 32'd0);

        // randomized stretch against the model
        do_reset();
        repeat (120) begin
            if ($urandom_range(0, 29) == 0) begin
                CLEAR = 1'b0;
                tick();
                CLEAR = 1'b1;
            end
            LOOP_RAW  = 1'($urandom_range(0, 1));
            CNTRY_SIG = 2'($urandom_range(0, 3));
            ticks(int'($urandom_range(1, 12)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
